// File: rtl/sram_row_ctrl.sv
// Request sequencer for a 32-bit-wide SRAM row array: precharge, word line, sense, respond.
// Every array control and response output is a flop, so no request input reaches an output directly.
module sram_row_ctrl #(
  parameter int unsigned AddrW     = 4,
  parameter int unsigned Rows      = 16,
  parameter int unsigned PreCycles = 1,
  parameter int unsigned WlCycles  = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [AddrW-1:0] req_addr_i,
  input  logic [31:0]      req_wdata_i,
  output logic             rsp_valid_o,
  output logic             rsp_err_o,
  output logic [31:0]      rsp_rdata_o,
  output logic [Rows-1:0]  wl_o,
  output logic             precharge_o,
  output logic             bl_drive_o,
  output logic [31:0]      bl_wdata_o,
  output logic             sense_en_o,
  input  logic [31:0]      bl_rdata_i
);

  localparam int unsigned CntMax = (PreCycles > WlCycles) ? PreCycles : WlCycles;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [2:0] {StIdle, StPre, StWlOn, StSense, StResp} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [AddrW-1:0]   addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               err_q, err_d;

  logic               req_ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0]        rsp_rdata_q;
  logic [Rows-1:0]    wl_q;
  logic               precharge_q, bl_drive_q, sense_en_q;
  logic [31:0]        bl_wdata_q;

  logic accept, req_err;

  assign accept  = (state_q == StIdle) && req_ready_q && req_valid_i;
  assign req_err = 32'(req_addr_i) >= Rows;

  function automatic logic [Rows-1:0] row_decode(input logic [AddrW-1:0] a);
    logic [Rows-1:0] d;
    for (int unsigned i = 0; i < Rows; i++) begin
      d[i] = (32'(a) == i);
    end
    return d;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          err_d   = req_err;
          state_d = StPre;
          // Error requests spend one silent cycle in StPre so the response lands one edge later.
          cnt_d   = req_err ? '0 : CntW'(PreCycles - 1);
        end
      end
      StPre: begin
        if (cnt_q == '0) begin
          state_d = err_q ? StResp : StWlOn;
          cnt_d   = CntW'(WlCycles - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWlOn: begin
        if (cnt_q == '0) begin
          state_d = we_q ? StResp : StSense;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSense: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      wl_q        <= '0;
      precharge_q <= 1'b0;
      bl_drive_q  <= 1'b0;
      bl_wdata_q  <= '0;
      sense_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      // Outputs are registered from the next state so they line up with state_q.
      req_ready_q <= (state_d == StIdle);
      rsp_valid_q <= (state_d == StResp);
      rsp_err_q   <= (state_d == StResp) && err_d;
      precharge_q <= (state_d == StPre) && !err_d;
      wl_q        <= ((state_d == StWlOn) || (state_d == StSense)) ? row_decode(addr_d) : '0;
      bl_drive_q  <= (state_d == StWlOn) && we_d;
      bl_wdata_q  <= ((state_d == StWlOn) && we_d) ? wdata_d : '0;
      sense_en_q  <= (state_d == StSense);
      if (state_q == StSense) begin
        rsp_rdata_q <= bl_rdata_i;
      end
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign wl_o        = wl_q;
  assign precharge_o = precharge_q;
  assign bl_drive_o  = bl_drive_q;
  assign bl_wdata_o  = bl_wdata_q;
  assign sense_en_o  = sense_en_q;

endmodule
